muldiv_hilo: RTL and testbench



---
 rtl/muldiv_hilo.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle integer multiply/divide unit with HI/LO registers.
// Handles MULTU/MULT (shift-add) and DIVU/DIV (restoring shift-subtract),
// plus MTHI/MTLO writes. One radix-2 step per cycle; a result is ready
// WIDTH+2 cycles after start.
//
// Handshake (start/busy/done):
//   start is a single-cycle request that is only looked at in IDLE. The cycle
//   after it is accepted busy rises and stays high through the DONE cycle.
//   done pulses for exactly one cycle, and hi/lo hold the new result during
//   that cycle. A start while busy is dropped without touching the operation.
//   A new start is accepted in the cycle after done.
//
// Optional build macro: MULDIV_DIVZERO_FLAG_EN adds the div_zero status output.
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIVZERO_FLAG_EN
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] lo
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;     // op[1]: divide when set
  logic [WIDTH-1:0] a_r;        // original dividend, returned as HI on divide by zero
  logic [WIDTH-1:0] mag_b;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_hi;     // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits becoming quotient
  logic             neg_q;      // product or quotient must be negated
  logic             neg_r;      // remainder must be negated (follows sign of a)
  logic             b_zero;     // divisor was zero

  // Operand magnitudes and signs for the signed forms (op[0]=1).
  logic             sgn;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;

  // Operand conditioning at start: magnitudes of signed operands.
  always_comb begin
    sgn      = op[0];
    mag_a_in = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b_in = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    // The partial remainder stays below the divisor, so the MSB of the
    // difference is a clean borrow flag.
    div_ge    = ~div_diff[WIDTH];
    step_hi   = '0;
    step_lo   = '0;
    if (is_div) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the raw magnitude result, including the divide-by-zero case.
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_mag = {acc_hi, acc_lo};
    prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    fix_hi   = '0;
    fix_lo   = '0;
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_r;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
        fix_lo = neg_q ? (~acc_lo + 1'b1) : acc_lo;
      end
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM with registered busy/done and the HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      a_r      <= '0;
      mag_b    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // start takes priority; a same-cycle MTHI/MTLO is dropped.
            state  <= S_CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            a_r    <= a;
            mag_b  <= mag_b_in;
            acc_hi <= '0;
            acc_lo <= mag_a_in;
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & a[WIDTH-1];
            b_zero <= (b == '0);
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          // hi/lo change only on this edge, which enters DONE.
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_DONE;
`ifdef MULDIV_DIVZERO_FLAG_EN
          div_zero <= is_div & b_zero;
`endif
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vector table plus hand-written multi-cycle
// sequences (start/write while busy, reset mid-operation, MTHI/MTLO rules).
module tb_muldiv_hilo;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic         div_zero;
`endif

  int tests = 0;
  int fails = 0;

  muldiv_hilo #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi),
`ifdef MULDIV_DIVZERO_FLAG_EN
    .lo(lo), .div_zero(div_zero)
`else
    .lo(lo)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for done. With inj=1, a stray start is
  // pulsed in cycle 10 and an MTHI in cycle 12 of the operation.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit inj, output int lat, output int busy_bad, output int hold_bad);
    logic [W-1:0] ph, pl;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    ph = hi; pl = lo;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_bad = 0; hold_bad = 0;
    while (!done && cyc < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (hi !== ph || lo !== pl) hold_bad++;
      if (inj) begin
        if (cyc == 10) begin start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; end
        if (cyc == 11) start = 1'b0;
        if (cyc == 12) begin wr_hi = 1'b1; wdata = 32'h55; end
        if (cyc == 13) wr_hi = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) busy_bad++;
    lat = cyc;
  endtask

  initial begin
    int lat, bb, hb, ndone;
    string nm;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{2'b01, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[7]  = '{2'b10, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};
    vecs[8]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b00, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0};
    vecs[11] = '{2'b11, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};

    // Reset
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("reset_div_zero", 64'(div_zero), 64'd0);
`endif
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bb, hb);
      nm = $sformatf("v%0d", i);
      check({nm, "_latency"}, 64'(lat), 64'(LAT));
      check({nm, "_hi"}, 64'(hi), 64'(vecs[i].hi));
      check({nm, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      check({nm, "_busy_bad"}, 64'(bb), 64'd0);
      check({nm, "_hold_bad"}, 64'(hb), 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
      check({nm, "_div_zero"}, 64'(div_zero), 64'(vecs[i].dz));
`endif
      @(negedge clk);
      check({nm, "_done_pulse"}, 64'(done), 64'd0);
      check({nm, "_busy_after"}, 64'(busy), 64'd0);
    end

    // Start and MTHI while busy are ignored
    run_op(2'b10, 32'd1000, 32'd7, 1'b1, lat, bb, hb);
    check("inj_latency", 64'(lat), 64'(LAT));
    check("inj_hi", 64'(hi), 64'd6);
    check("inj_lo", 64'(lo), 64'd142);
    check("inj_busy_bad", 64'(bb), 64'd0);
    check("inj_hold_bad", 64'(hb), 64'd0);
    @(negedge clk);
    check("inj_idle_busy", 64'(busy), 64'd0);

    // Reset mid-operation: cycle 15 of a MULTU
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 15; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", 64'(ndone), 64'd0);

    // MTLO, then MTHI+MTLO together
    wr_lo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtlo_hi", 64'(hi), 64'd0);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthilo_hi", 64'(hi), 64'h1234);
    check("mthilo_lo", 64'(lo), 64'h1234);

    // start and MTHI in the same IDLE cycle: start wins
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; wr_hi = 1'b1; wdata = 32'h99;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    check("start_wins_hi", 64'(hi), 64'h1234);
    check("start_wins_busy", 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("start_wins_latency", 64'(lat), 64'(LAT));
    check("start_wins_res_hi", 64'(hi), 64'd0);
    check("start_wins_res_lo", 64'(lo), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
